mem_port_arbiter: RTL and testbench

- Sits directly downstream of the core's instruction and data memory ports.
- Merges imem and dmem request streams onto one shared backing-memory bus, one outstanding transaction at a time.
- Routes each response back to its requester and flags transactions that time out.
- Lets a single-ported RAM or external bus serve the core.

---
 rtl/mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Merges the core's instruction (imem) and data (dmem) request streams onto
//   one shared backing-memory bus. Only one transaction is outstanding at a
//   time. Each response is routed back to the port that issued the request.
//   A transaction that waits too long for its response is completed with an
//   error response instead.
//
// Build option:
//   MEM_PORT_ARBITER_RR_EN  defined   -> round-robin between imem and dmem
//                                        when both request in the same cycle
//                           undefined -> dmem always wins (fixed priority)
//
// Parameters:
//   ADDR_W       address width for all ports
//   DATA_W       data width for all ports (byte-mask width is DATA_W/8)
//   TIMEOUT_CYC  max cycles spent waiting for a response; 0 disables it
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   imem_req_*          fetch request in (valid/addr), ready out
//   imem_resp_*         fetch response out (valid pulse, data, err)
//   dmem_req_*          data request in (valid/addr/wen/wdata/wmask), ready out
//   dmem_resp_*         data response out (valid pulse, data, err)
//   mem_req_*           backing-bus request out, ready in
//   mem_resp_*          backing-bus response in (valid, data)
//
// Handshake: a request transfers on any rising edge where its valid and
// ready are both 1. Request ready is a combinational function of valid and is
// only ever 1 while idle; the backing request holds every field stable from
// the first cycle valid is raised until the cycle ready is seen. Response
// valids are one-cycle pulses; response data/err hold until the next response
// to the same port.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_req_valid,
    input  logic [ADDR_W-1:0]   imem_req_addr,
    output logic                imem_req_ready,
    output logic                imem_resp_valid,
    output logic [DATA_W-1:0]   imem_resp_data,
    output logic                imem_resp_err,
    input  logic                dmem_req_valid,
    input  logic [ADDR_W-1:0]   dmem_req_addr,
    input  logic                dmem_req_wen,
    input  logic [DATA_W-1:0]   dmem_req_wdata,
    input  logic [DATA_W/8-1:0] dmem_req_wmask,
    output logic                dmem_req_ready,
    output logic                dmem_resp_valid,
    output logic [DATA_W-1:0]   dmem_resp_data,
    output logic                dmem_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int MASK_W = DATA_W / 8;

    // The counter holds "WAIT cycles already spent without a response", so it
    // only needs to reach TIMEOUT_CYC-1: the cycle that sees that value with
    // no response is the TIMEOUT_CYC-th waiting cycle and fires the timeout.
    localparam int CNT_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int TO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Latched request; owner 1 = dmem, 0 = imem.
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_imem_resp_valid;
    logic [DATA_W-1:0]   r_imem_resp_data;
    logic                r_imem_resp_err;
    logic                r_dmem_resp_valid;
    logic [DATA_W-1:0]   r_dmem_resp_data;
    logic                r_dmem_resp_err;

    logic                w_grant_dmem;
    logic                w_accept;
    logic                w_resp_fire;
    logic                w_timeout;
    logic                w_to_hit;

`ifdef MEM_PORT_ARBITER_RR_EN
    // Last port granted: 1 = dmem, 0 = imem.
    logic                r_last_grant;

    // On a tie the port that was not granted last wins.
    assign w_grant_dmem = dmem_req_valid & (~imem_req_valid | ~r_last_grant);
`else
    assign w_grant_dmem = dmem_req_valid;
`endif

    assign w_to_hit = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and combinational outputs. Everything is held off
    // while reset is asserted so no handshake can complete that the
    // registers would then fail to record.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        imem_req_ready = 1'b0;
        dmem_req_ready = 1'b0;
        mem_req_valid  = 1'b0;
        w_accept       = 1'b0;
        w_resp_fire    = 1'b0;
        w_timeout      = 1'b0;
        if (reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (imem_req_valid || dmem_req_valid) begin
                        w_accept       = 1'b1;
                        imem_req_ready = ~w_grant_dmem;
                        dmem_req_ready = w_grant_dmem;
                        w_state_nxt    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (mem_resp_valid) begin
                        w_resp_fire = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_to_hit) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, wait counter, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner           <= 1'b0;
            r_addr            <= '0;
            r_wen             <= 1'b0;
            r_wdata           <= '0;
            r_wmask           <= '0;
            r_cnt             <= '0;
            r_imem_resp_valid <= 1'b0;
            r_imem_resp_data  <= '0;
            r_imem_resp_err   <= 1'b0;
            r_dmem_resp_valid <= 1'b0;
            r_dmem_resp_data  <= '0;
            r_dmem_resp_err   <= 1'b0;
        end else begin
            r_imem_resp_valid <= 1'b0;
            r_dmem_resp_valid <= 1'b0;

            if (w_accept) begin
                r_owner <= w_grant_dmem;
                if (w_grant_dmem) begin
                    r_addr  <= dmem_req_addr;
                    r_wen   <= dmem_req_wen;
                    r_wdata <= dmem_req_wdata;
                    r_wmask <= dmem_req_wmask;
                end else begin
                    // Fetches are full-width reads.
                    r_addr  <= imem_req_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '1;
                end
            end

            // Cleared throughout ISSUE so WAIT always starts counting at 0.
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_resp_fire || w_timeout) begin
                if (r_owner) begin
                    r_dmem_resp_valid <= 1'b1;
                    r_dmem_resp_data  <= (w_resp_fire && !r_wen) ? mem_resp_data : '0;
                    r_dmem_resp_err   <= w_timeout;
                end else begin
                    r_imem_resp_valid <= 1'b1;
                    r_imem_resp_data  <= w_resp_fire ? mem_resp_data : '0;
                    r_imem_resp_err   <= w_timeout;
                end
            end
        end
    end

`ifdef MEM_PORT_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_dmem;
        end
    end
`endif

    assign mem_req_addr    = r_addr;
    assign mem_req_wen     = r_wen;
    assign mem_req_wdata   = r_wdata;
    assign mem_req_wmask   = r_wmask;

    assign imem_resp_valid = r_imem_resp_valid;
    assign imem_resp_data  = r_imem_resp_data;
    assign imem_resp_err   = r_imem_resp_err;
    assign dmem_resp_valid = r_dmem_resp_valid;
    assign dmem_resp_data  = r_dmem_resp_data;
    assign dmem_resp_err   = r_dmem_resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_port_arbiter.
// A transaction-level model (busy flag, latched request, count of waiting
// cycles, visible response registers) predicts every output each cycle.
// Inputs change 1 ns after the rising edge; the model compares and advances
// on the falling edge; directed checks sample 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clk;
    logic          reset;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          imem_resp_err;
    logic          dmem_req_valid;
    logic [AW-1:0] dmem_req_addr;
    logic          dmem_req_wen;
    logic [DW-1:0] dmem_req_wdata;
    logic [MW-1:0] dmem_req_wmask;
    logic          dmem_req_ready;
    logic          dmem_resp_valid;
    logic [DW-1:0] dmem_resp_data;
    logic          dmem_resp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wen(dmem_req_wen), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_wmask(dmem_req_wmask), .dmem_req_ready(dmem_req_ready),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .dmem_resp_err(dmem_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy, m_hs, m_owner_d, m_wen, m_last_d;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    int          m_waited;
    bit          v_ivalid, v_dvalid, v_ierr, v_derr;
    logic [31:0] v_idata, v_ddata;
    // snapshot of this cycle's expectations, for directed pins
    bit          e_iready, e_dready, e_mvalid, e_ivalid, e_dvalid;
    logic [31:0] e_idata, e_ddata;

    task automatic deliver(input logic [31:0] data, input bit err);
        if (m_owner_d) begin
            v_dvalid = 1'b1; v_ddata = data; v_derr = err;
        end else begin
            v_ivalid = 1'b1; v_idata = data; v_ierr = err;
        end
        m_busy = 1'b0;
    endtask

    initial begin
        bit g_d;
        m_busy = 0; m_hs = 0; m_owner_d = 0; m_wen = 0; m_last_d = 0;
        m_addr = 0; m_wdata = 0; m_wmask = 0; m_waited = 0;
        v_ivalid = 0; v_dvalid = 0; v_ierr = 0; v_derr = 0;
        v_idata = 0; v_ddata = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            // which port wins if a request is taken now
            if (imem_req_valid && dmem_req_valid) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                g_d = (m_last_d == 1'b0);
`else
                g_d = 1'b1;
`endif
            end else begin
                g_d = dmem_req_valid;
            end
            e_iready = reset && !m_busy && imem_req_valid && !g_d;
            e_dready = reset && !m_busy && dmem_req_valid && g_d;
            e_mvalid = reset && m_busy && !m_hs;
            e_ivalid = v_ivalid; e_idata = v_idata;
            e_dvalid = v_dvalid; e_ddata = v_ddata;

            chk("imem_req_ready", imem_req_ready, e_iready);
            chk("dmem_req_ready", dmem_req_ready, e_dready);
            chk("mem_req_valid", mem_req_valid, e_mvalid);
            if (e_mvalid) begin
                chk("mem_req_addr", mem_req_addr, m_addr);
                chk("mem_req_wen", mem_req_wen, m_wen);
                chk("mem_req_wdata", mem_req_wdata, m_wdata);
                chk("mem_req_wmask", mem_req_wmask, m_wmask);
            end
            chk("imem_resp_valid", imem_resp_valid, v_ivalid);
            chk("imem_resp_data", imem_resp_data, v_idata);
            chk("imem_resp_err", imem_resp_err, v_ierr);
            chk("dmem_resp_valid", dmem_resp_valid, v_dvalid);
            chk("dmem_resp_data", dmem_resp_data, v_ddata);
            chk("dmem_resp_err", dmem_resp_err, v_derr);

            // advance to what the coming rising edge produces
            if (!reset) begin
                m_busy = 0; m_hs = 0; m_owner_d = 0; m_wen = 0; m_last_d = 0;
                m_addr = 0; m_wdata = 0; m_wmask = 0; m_waited = 0;
                v_ivalid = 0; v_dvalid = 0; v_ierr = 0; v_derr = 0;
                v_idata = 0; v_ddata = 0;
            end else begin
                v_ivalid = 0;
                v_dvalid = 0;
                if (!m_busy) begin
                    if (imem_req_valid || dmem_req_valid) begin
                        m_owner_d = g_d;
                        m_last_d  = g_d;
                        m_addr    = g_d ? dmem_req_addr : imem_req_addr;
                        m_wen     = g_d ? dmem_req_wen : 1'b0;
                        m_wdata   = g_d ? dmem_req_wdata : 32'h0;
                        m_wmask   = g_d ? dmem_req_wmask : 4'hF;
                        m_busy    = 1;
                        m_hs      = 0;
                    end
                end else if (!m_hs) begin
                    if (mem_req_ready) begin
                        m_hs = 1;
                        m_waited = 0;
                    end
                end else if (mem_resp_valid) begin
                    deliver((m_owner_d && m_wen) ? 32'h0 : mem_resp_data, 1'b0);
                end else begin
                    m_waited++;
                    if (TO != 0 && m_waited == TO) deliver(32'h0, 1'b1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_valid = 0; imem_req_addr = 0;
        dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_wen = 0;
        dmem_req_wdata = 0; dmem_req_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit grants[4];
        bit exp_d;
        int ngrant;
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // 1) imem read at 0x100, 0xDEADBEEF one cycle after the handshake
        imem_req_valid = 1; imem_req_addr = 32'h100; mem_req_ready = 1;
        look();
        chk("t1_imem_ready_c0", imem_req_ready, 1'b1);
        chk("t1_dmem_ready_c0", dmem_req_ready, 1'b0);
        chk("t1_model_iready", e_iready, 1'b1);
        step(); imem_req_valid = 0;
        look();
        chk("t1_mem_valid_c1", mem_req_valid, 1'b1);
        chk("t1_mem_addr_c1", mem_req_addr, 32'h100);
        chk("t1_mem_wmask_c1", mem_req_wmask, 4'hF);
        chk("t1_mem_wen_c1", mem_req_wen, 1'b0);
        step(); mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
        look();
        step(); mem_resp_valid = 0; mem_req_ready = 0;
        look();
        chk("t1_imem_resp_valid_c3", imem_resp_valid, 1'b1);
        chk("t1_imem_resp_data_c3", imem_resp_data, 32'hDEADBEEF);
        chk("t1_dmem_resp_valid_c3", dmem_resp_valid, 1'b0);
        chk("t1_model_idata", e_idata, 32'hDEADBEEF);

        // 2) dmem store, backing not ready for 3 cycles
        step();
        dmem_req_valid = 1; dmem_req_addr = 32'h20; dmem_req_wen = 1;
        dmem_req_wdata = 32'h12345678; dmem_req_wmask = 4'h3;
        look();
        chk("t2_dmem_ready", dmem_req_ready, 1'b1);
        step(); dmem_req_valid = 0; dmem_req_wdata = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            look();
            chk("t2_mem_valid", mem_req_valid, 1'b1);
            chk("t2_mem_addr", mem_req_addr, 32'h20);
            chk("t2_mem_wdata", mem_req_wdata, 32'h12345678);
            chk("t2_mem_wmask", mem_req_wmask, 4'h3);
            chk("t2_mem_wen", mem_req_wen, 1'b1);
            step();
        end
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA5555;
        look();
        step(); mem_resp_valid = 0;
        look();
        chk("t2_dmem_resp_valid", dmem_resp_valid, 1'b1);
        chk("t2_dmem_resp_data", dmem_resp_data, 32'h0);
        chk("t2_dmem_resp_err", dmem_resp_err, 1'b0);
        chk("t2_imem_resp_valid", imem_resp_valid, 1'b0);
        chk("t2_model_dvalid", e_dvalid, 1'b1);
        step();
        look();
        chk("t2_dmem_resp_pulse_end", dmem_resp_valid, 1'b0);

        // 3) both ports valid every cycle for 4 transactions
        step();
        imem_req_valid = 1; imem_req_addr = 32'h200;
        dmem_req_valid = 1; dmem_req_addr = 32'h300; dmem_req_wen = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h0BADF00D;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            look();
            if ((imem_req_ready || dmem_req_ready) && ngrant < 4) begin
                grants[ngrant] = dmem_req_ready;
                ngrant++;
            end
            step();
            mem_resp_data = mem_resp_data + 32'h11;
        end
        idle_inputs();
        chk("t3_grant_count", ngrant, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            exp_d = (k % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            chk("t3_grant_is_dmem", grants[k], exp_d);
        end
        look();

        // 4) timeout: no response after the handshake
        step();
        dmem_req_valid = 1; dmem_req_addr = 32'h40; dmem_req_wen = 0; mem_req_ready = 1;
        look();
        step(); dmem_req_valid = 0;
        look();
        step(); mem_req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("t4_no_resp_yet", dmem_resp_valid, 1'b0);
            step();
        end
        look();
        chk("t4_to_valid", dmem_resp_valid, 1'b1);
        chk("t4_to_err", dmem_resp_err, 1'b1);
        chk("t4_to_data", dmem_resp_data, 32'h0);
        step(); mem_resp_valid = 1; mem_resp_data = 32'h77777777;
        look();
        chk("t4_pulse_end", dmem_resp_valid, 1'b0);
        chk("t4_err_held", dmem_resp_err, 1'b1);
        step(); mem_resp_valid = 0;
        look();
        chk("t4_stray_dmem", dmem_resp_valid, 1'b0);
        chk("t4_stray_imem", imem_resp_valid, 1'b0);

        // 5) reset while in WAIT
        step();
        imem_req_valid = 1; imem_req_addr = 32'h80; mem_req_ready = 1;
        look();
        step(); imem_req_valid = 0;
        look();
        step(); mem_req_ready = 0; reset = 0;
        look();
        step(); reset = 1; mem_resp_valid = 1; mem_resp_data = 32'h5555AAAA;
        look();
        chk("t5_imem_req_ready", imem_req_ready, 1'b0);
        chk("t5_dmem_req_ready", dmem_req_ready, 1'b0);
        chk("t5_mem_req_valid", mem_req_valid, 1'b0);
        chk("t5_mem_req_addr", mem_req_addr, 32'h0);
        chk("t5_mem_req_wen", mem_req_wen, 1'b0);
        chk("t5_mem_req_wdata", mem_req_wdata, 32'h0);
        chk("t5_mem_req_wmask", mem_req_wmask, 4'h0);
        chk("t5_imem_resp_valid", imem_resp_valid, 1'b0);
        chk("t5_imem_resp_data", imem_resp_data, 32'h0);
        chk("t5_imem_resp_err", imem_resp_err, 1'b0);
        chk("t5_dmem_resp_valid", dmem_resp_valid, 1'b0);
        chk("t5_dmem_resp_data", dmem_resp_data, 32'h0);
        chk("t5_dmem_resp_err", dmem_resp_err, 1'b0);
        step(); mem_resp_valid = 0;
        look();
        chk("t5_late_resp_ignored", imem_resp_valid, 1'b0);
        step(); imem_req_valid = 1; imem_req_addr = 32'h44; mem_req_ready = 1;
        look();
        chk("t5_new_imem_ready", imem_req_ready, 1'b1);
        step(); imem_req_valid = 0;
        look();
        step(); mem_resp_valid = 1; mem_resp_data = 32'hCAFEF00D;
        look();
        step(); idle_inputs();
        look();
        chk("t5_new_resp_valid", imem_resp_valid, 1'b1);
        chk("t5_new_resp_data", imem_resp_data, 32'hCAFEF00D);

        // 6) randomized traffic, occasional reset
        for (int c = 0; c < 4000; c++) begin
            step();
            imem_req_valid = ($urandom_range(0, 2) != 0);
            imem_req_addr  = $urandom;
            dmem_req_valid = ($urandom_range(0, 2) != 0);
            dmem_req_addr  = $urandom;
            dmem_req_wen   = $urandom_range(0, 1);
            dmem_req_wdata = $urandom;
            dmem_req_wmask = 4'($urandom_range(0, 15));
            mem_req_ready  = $urandom_range(0, 1);
            mem_resp_valid = ($urandom_range(0, 3) == 0);
            mem_resp_data  = $urandom;
            reset          = ($urandom_range(0, 299) != 0);
        end
        step();
        reset = 1;
        idle_inputs();
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
